// File: rtl/ethernet_pkg.sv
// ---------------------------------------------------------------------------
// ethernet_pkg
// Shared definitions for the clause-22 MDIO master:
//   - mdio_state_e : frame sequencer states
//   - MDIO_ST / MDIO_OP_* : start-of-frame and opcode bit patterns
//   - next_field() : field order within a management frame
// ---------------------------------------------------------------------------
package ethernet_pkg;

    typedef enum logic [3:0] {
        IDLE,
        PREAMBLE,
        START,
        OPCODE,
        PHY_ADDR,
        REG_ADDR,
        TURNAROUND,
        DATA,
        DONE
    } mdio_state_e;

    localparam logic [1:0] MDIO_ST       = 2'b01;
    localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
    localparam logic [1:0] MDIO_OP_READ  = 2'b10;

    // Field that follows s on the wire; DATA is the last field of a frame.
    function automatic mdio_state_e next_field(input mdio_state_e s);
        case (s)
            PREAMBLE:   next_field = START;
            START:      next_field = OPCODE;
            OPCODE:     next_field = PHY_ADDR;
            PHY_ADDR:   next_field = REG_ADDR;
            REG_ADDR:   next_field = TURNAROUND;
            TURNAROUND: next_field = DATA;
            DATA:       next_field = DONE;
            default:    next_field = IDLE;
        endcase
    endfunction

endpackage

// File: rtl/ethernet_mdc_generator.sv
// ---------------------------------------------------------------------------
// ethernet_mdc_generator
// Produces MDC and per-bit timing strobes. One MDIO bit spans 2*CLK_DIV
// clk_i cycles: MDC low for the first CLK_DIV, high for the last CLK_DIV.
// The counter is held at zero while disabled, so the first enabled cycle is
// always the start of a bit.
// Ports:
//   clk_i, rst_n_i : clock, synchronous active-low reset
//   en_i           : run the bit timer (frame in progress)
//   mdc_o          : management clock (low while disabled)
//   bit_start_o    : first clk_i cycle of a bit
//   sample_o       : last clk_i cycle of a bit (end of MDC-high phase)
// ---------------------------------------------------------------------------
module ethernet_mdc_generator #(
    parameter int CLK_DIV = 5
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    output logic mdc_o,
    output logic bit_start_o,
    output logic sample_o
);

    localparam int              CNT_W = $clog2(2 * CLK_DIV);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(2 * CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mdc_o       = en_i && (cnt_q >= HALF);
    assign bit_start_o = en_i && (cnt_q == '0);
    assign sample_o    = en_i && (cnt_q == LAST);

endmodule

// File: rtl/ethernet_mdio_master.sv
// ---------------------------------------------------------------------------
// ethernet_mdio_master
// IEEE 802.3 clause-22 MDIO management master. Accepts one write or read
// request at a time and serialises the frame on smii_mdc_o / smii_mdio_io.
// Ports:
//   clk_i, rst_n_i          : clock, synchronous active-low reset
//   phy_address_i[4:0]      : target PHY, sampled at acceptance
//   reg_address_i[4:0]      : PHY register, sampled at acceptance
//   write_i, read_i         : single-cycle request strobes (write wins)
//   data_i[15:0]            : write data, sampled at acceptance
//   data_o[15:0]            : data of the last completed read
//   busy_o                  : frame in progress
//   done_o                  : one-cycle completion pulse
//   error_o                 : read saw no PHY response on turnaround
//   smii_mdc_o              : management clock
//   smii_mdio_io            : management data, released when not driving
// ---------------------------------------------------------------------------
module ethernet_mdio_master #(
    parameter int CLK_DIV      = 5,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [4:0]  phy_address_i,
    input  logic [4:0]  reg_address_i,
    input  logic        write_i,
    input  logic        read_i,
    input  logic [15:0] data_i,
    output logic [15:0] data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic        smii_mdc_o,
    inout  wire         smii_mdio_io
);

    import ethernet_pkg::*;

    mdio_state_e state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] shreg_q, shreg_d;
    logic        wr_q, wr_d;
    logic [4:0]  phy_q, phy_d;
    logic [4:0]  reg_q, reg_d;
    logic        ta_err_q, ta_err_d;
    logic [15:0] data_q, data_d;

    logic       busy;
    logic       bit_start;
    logic       sample;
    logic       mdio_in;
    logic       mdio_oe;
    logic       mdio_out;
    logic [1:0] op_code;

    // Index of the last bit of each field.
    function automatic logic [4:0] field_last(input mdio_state_e s);
        case (s)
            PREAMBLE:           field_last = 5'(PREAMBLE_LEN - 1);
            PHY_ADDR, REG_ADDR: field_last = 5'd4;
            DATA:               field_last = 5'd15;
            default:            field_last = 5'd1;
        endcase
    endfunction

    assign busy    = (state_q != IDLE) && (state_q != DONE);
    assign mdio_in = smii_mdio_io;
    assign op_code = wr_q ? MDIO_OP_WRITE : MDIO_OP_READ;

    ethernet_mdc_generator #(
        .CLK_DIV (CLK_DIV)
    ) u_mdc (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .en_i        (busy),
        .mdc_o       (smii_mdc_o),
        .bit_start_o (bit_start),
        .sample_o    (sample)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        wr_d      = wr_q;
        phy_d     = phy_q;
        reg_d     = reg_q;
        ta_err_d  = ta_err_q;
        data_d    = data_q;

        if (!busy) begin
            // DONE behaves like IDLE so a request can follow back-to-back.
            state_d   = IDLE;
            bit_cnt_d = '0;
            if (write_i || read_i) begin
                state_d  = (PREAMBLE_LEN == 0) ? START : PREAMBLE;
                wr_d     = write_i;
                phy_d    = phy_address_i;
                reg_d    = reg_address_i;
                shreg_d  = data_i;
                ta_err_d = 1'b0;
            end
        end else begin
            // A read reuses the shift register for capture; empty it as the
            // PHY takes over the line.
            if (bit_start && !wr_q && (state_q == TURNAROUND) && (bit_cnt_q == 5'd0)) begin
                shreg_d = '0;
            end
            if (sample) begin
                if (!wr_q && (state_q == TURNAROUND) && (bit_cnt_q == 5'd1)) begin
                    ta_err_d = mdio_in;
                end
                if (state_q == DATA) begin
                    shreg_d = {shreg_q[14:0], wr_q ? 1'b0 : mdio_in};
                    if (!wr_q && (bit_cnt_q == 5'd15)) begin
                        data_d = {shreg_q[14:0], mdio_in};
                    end
                end
                if (bit_cnt_q == field_last(state_q)) begin
                    state_d   = next_field(state_q);
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end
            end
        end
    end

    // Serial output: fields change only when state/bit counter advance,
    // which happens at the boundary into the next bit.
    always_comb begin
        mdio_oe  = 1'b0;
        mdio_out = 1'b1;
        case (state_q)
            PREAMBLE: begin
                mdio_oe  = 1'b1;
                mdio_out = 1'b1;
            end
            START: begin
                mdio_oe  = 1'b1;
                mdio_out = bit_cnt_q[0] ? MDIO_ST[0] : MDIO_ST[1];
            end
            OPCODE: begin
                mdio_oe  = 1'b1;
                mdio_out = bit_cnt_q[0] ? op_code[0] : op_code[1];
            end
            PHY_ADDR: begin
                mdio_oe  = 1'b1;
                mdio_out = phy_q[3'd4 - bit_cnt_q[2:0]];
            end
            REG_ADDR: begin
                mdio_oe  = 1'b1;
                mdio_out = reg_q[3'd4 - bit_cnt_q[2:0]];
            end
            TURNAROUND: begin
                mdio_oe  = wr_q;
                mdio_out = ~bit_cnt_q[0];
            end
            DATA: begin
                mdio_oe  = wr_q;
                mdio_out = shreg_q[15];
            end
            default: begin
                mdio_oe  = 1'b0;
                mdio_out = 1'b1;
            end
        endcase
    end

    assign smii_mdio_io = mdio_oe ? mdio_out : 1'bz;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
        end
    end

    always_ff @(posedge clk_i) begin
        shreg_q  <= shreg_d;
        wr_q     <= wr_d;
        phy_q    <= phy_d;
        reg_q    <= reg_d;
        ta_err_q <= ta_err_d;
    end

    assign data_o  = data_q;
    assign busy_o  = busy;
    assign done_o  = (state_q == DONE);
    assign error_o = (state_q == DONE) && !wr_q && ta_err_q;

endmodule
